// File: rtl/nn_driver_pkg.sv
// Shared definitions for the neural-network image driver.
// Holds the FSM state type, image geometry, class range and the
// helper that flags an out-of-range prediction.
package nn_driver_pkg;

  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int NUM_PIX     = IMG_W * IMG_H;
  localparam int CLASS_W     = 4;
  localparam int NUM_CLASSES = 10;
  localparam int CNT_W       = 16;
  localparam int PIX_IDX_W   = $clog2(NUM_PIX);
  // One spare code so row_cnt can step past the last row index.
  localparam int ROW_IDX_W   = $clog2(IMG_H + 1);

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    WAIT_CTRL = 3'd1,
    STREAM    = 3'd2,
    WAIT_PRED = 3'd3,
    ACK       = 3'd4,
    RESULT    = 3'd5
  } state_t;

  // High when the controller reports a class outside 0..NUM_CLASSES-1.
  function automatic logic class_illegal(input logic [CLASS_W-1:0] cls);
    return (int'(cls) >= NUM_CLASSES);
  endfunction

endpackage

// File: rtl/nn_pixel_serializer.sv
// Pixel buffer and serializer.
// Stores one image as IMG_H row words and, after a start pulse, shifts it
// out one pixel per clock, row 0 bit 0 first.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   row_we/row_sel/row_data  row write port (row_sel in 0..IMG_H-1)
//   start               begin a transfer (pixel 0 appears next cycle)
//   done                high during the last pixel cycle of a transfer
//   active              registered, high for every pixel cycle
//   pixel               registered current pixel, 0 when idle
module nn_pixel_serializer
  import nn_driver_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 row_we,
  input  logic [ROW_IDX_W-1:0] row_sel,
  input  logic [IMG_W-1:0]     row_data,
  input  logic                 start,
  output logic                 done,
  output logic                 active,
  output logic                 pixel
);

  logic [NUM_PIX-1:0]   pix_buf_r;
  logic [PIX_IDX_W-1:0] idx_r;
  logic                 active_r;
  logic                 pixel_r;

  // idx_r holds the index of the next pixel to present, so the transfer
  // ends once it reaches NUM_PIX while the last pixel is on the output.
  assign done   = active_r && (idx_r == PIX_IDX_W'(NUM_PIX));
  assign active = active_r;
  assign pixel  = pixel_r;

  // Buffer write port plus pixel index / output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_buf_r <= '0;
      idx_r     <= '0;
      active_r  <= 1'b0;
      pixel_r   <= 1'b0;
    end else begin
      if (row_we) begin
        for (int r = 0; r < IMG_H; r++) begin
          if (row_sel == ROW_IDX_W'(r)) begin
            pix_buf_r[r*IMG_W +: IMG_W] <= row_data;
          end
        end
      end
      if (start && !active_r) begin
        active_r <= 1'b1;
        pixel_r  <= pix_buf_r[0];
        idx_r    <= PIX_IDX_W'(1);
      end else if (active_r) begin
        if (done) begin
          active_r <= 1'b0;
          pixel_r  <= 1'b0;
          idx_r    <= '0;
        end else begin
          pixel_r <= pix_buf_r[idx_r];
          idx_r   <= idx_r + PIX_IDX_W'(1);
        end
      end else begin
        pixel_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nn_image_driver.sv
// Host-side front end for the neural-network controller.
// Collects a 28x28 binary image as row words, streams it bit-serially into
// the controller, acknowledges the prediction and offers the class
// downstream with a valid/ready handshake.
// Ports:
//   masterClk, reset        clock, synchronous active-high reset
//   row_valid/row_data/row_ready   upstream row word handshake
//   readyForInputs          controller idle, may take an image
//   inputsInbound/inputPixel       serial pixel stream to controller
//   predictionReady/predictionOut  prediction from controller
//   predictionRecieved      acknowledge back to controller
//   result_valid/result_class/result_err/result_ready  downstream result
//   image_count             completed images, wraps
//   busy                    not idle in LOAD with an empty buffer
module nn_image_driver
  import nn_driver_pkg::*;
(
  input  logic               masterClk,
  input  logic               reset,
  input  logic               row_valid,
  input  logic [IMG_W-1:0]   row_data,
  output logic               row_ready,
  input  logic               readyForInputs,
  output logic               inputsInbound,
  output logic               inputPixel,
  input  logic               predictionReady,
  input  logic [CLASS_W-1:0] predictionOut,
  output logic               predictionRecieved,
  output logic               result_valid,
  output logic [CLASS_W-1:0] result_class,
  output logic               result_err,
  input  logic               result_ready,
  output logic [CNT_W-1:0]   image_count,
  output logic               busy
);

  state_t               state_r, state_next_s;
  logic [ROW_IDX_W-1:0] row_cnt_r, row_cnt_next_s;
  logic                 row_ready_r, row_ready_d_s;
  logic                 pred_rcv_r, pred_rcv_d_s;
  logic                 result_valid_r, result_valid_d_s;
  logic [CLASS_W-1:0]   result_class_r;
  logic                 result_err_r;
  logic [CNT_W-1:0]     image_count_r;
  logic                 busy_r, busy_d_s;

  logic accept_s, start_s, done_s, capture_s, release_s, handoff_s;

  assign accept_s  = row_valid && row_ready_r && (state_r == LOAD);
  assign start_s   = (state_r == WAIT_CTRL) && readyForInputs;
  assign capture_s = (state_r == WAIT_PRED) && predictionReady;
  assign release_s = (state_r == ACK) && !predictionReady;
  assign handoff_s = (state_r == RESULT) && result_ready;

  nn_pixel_serializer u_ser (
    .clk      (masterClk),
    .reset    (reset),
    .row_we   (accept_s),
    .row_sel  (row_cnt_r),
    .row_data (row_data),
    .start    (start_s),
    .done     (done_s),
    .active   (inputsInbound),
    .pixel    (inputPixel)
  );

  // State, row counter and registered outputs.
  always_ff @(posedge masterClk) begin
    if (reset) begin
      state_r        <= LOAD;
      row_cnt_r      <= '0;
      row_ready_r    <= 1'b1;
      pred_rcv_r     <= 1'b0;
      result_valid_r <= 1'b0;
      result_class_r <= '0;
      result_err_r   <= 1'b0;
      image_count_r  <= '0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      row_cnt_r      <= row_cnt_next_s;
      row_ready_r    <= row_ready_d_s;
      pred_rcv_r     <= pred_rcv_d_s;
      result_valid_r <= result_valid_d_s;
      busy_r         <= busy_d_s;
      if (capture_s) begin
        result_class_r <= predictionOut;
        result_err_r   <= class_illegal(predictionOut);
      end
      if (release_s) begin
        image_count_r <= image_count_r + CNT_W'(1);
      end
    end
  end

  // Next-state and row counter update.
  always_comb begin
    state_next_s   = state_r;
    row_cnt_next_s = row_cnt_r;
    case (state_r)
      LOAD: begin
        if (accept_s) begin
          row_cnt_next_s = row_cnt_r + ROW_IDX_W'(1);
          if (row_cnt_r == ROW_IDX_W'(IMG_H - 1)) begin
            state_next_s = WAIT_CTRL;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = LOAD;
        end
      end
      WAIT_CTRL: state_next_s = start_s   ? STREAM    : WAIT_CTRL;
      STREAM:    state_next_s = done_s    ? WAIT_PRED : STREAM;
      WAIT_PRED: state_next_s = capture_s ? ACK       : WAIT_PRED;
      ACK:       state_next_s = release_s ? RESULT    : ACK;
      RESULT: begin
        if (handoff_s) begin
          state_next_s   = LOAD;
          row_cnt_next_s = '0;
        end else begin
          state_next_s = RESULT;
        end
      end
      default: begin
        state_next_s   = LOAD;
        row_cnt_next_s = '0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so the
  // registered outputs change together with the state.
  always_comb begin
    row_ready_d_s    = (state_next_s == LOAD);
    pred_rcv_d_s     = (state_next_s == ACK);
    result_valid_d_s = (state_next_s == RESULT);
    busy_d_s         = (state_next_s != LOAD) || (row_cnt_next_s != '0);
  end

  assign row_ready          = row_ready_r;
  assign predictionRecieved = pred_rcv_r;
  assign result_valid       = result_valid_r;
  assign result_class       = result_class_r;
  assign result_err         = result_err_r;
  assign image_count        = image_count_r;
  assign busy               = busy_r;

endmodule

// File: tb/tb_nn_image_driver.sv
module tb_nn_image_driver;

  localparam int W = 28;
  localparam int H = 28;
  localparam int N_CLASSES = 10;

  logic        masterClk = 1'b0;
  logic        reset;
  logic        row_valid;
  logic [W-1:0] row_data;
  logic        row_ready;
  logic        readyForInputs;
  logic        inputsInbound;
  logic        inputPixel;
  logic        predictionReady;
  logic [3:0]  predictionOut;
  logic        predictionRecieved;
  logic        result_valid;
  logic [3:0]  result_class;
  logic        result_err;
  logic        result_ready;
  logic [15:0] image_count;
  logic        busy;

  always #5 masterClk = ~masterClk;

  nn_image_driver dut (
    .masterClk          (masterClk),
    .reset              (reset),
    .row_valid          (row_valid),
    .row_data           (row_data),
    .row_ready          (row_ready),
    .readyForInputs     (readyForInputs),
    .inputsInbound      (inputsInbound),
    .inputPixel         (inputPixel),
    .predictionReady    (predictionReady),
    .predictionOut      (predictionOut),
    .predictionRecieved (predictionRecieved),
    .result_valid       (result_valid),
    .result_class       (result_class),
    .result_err         (result_err),
    .result_ready       (result_ready),
    .image_count        (image_count),
    .busy               (busy)
  );

  typedef struct packed {
    logic [3:0]  cls;
    logic        err;
    logic [15:0] cnt;
  } res_t;

  int          tests = 0;
  int          fails = 0;
  bit          pix_q[$];
  res_t        res_q[$];
  logic [W-1:0] img_tb [H];
  logic [15:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return inputsInbound;
      1: return predictionRecieved;
      2: return result_valid;
      3: return row_ready;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait (negedge sampling) for a DUT output to reach a level.
  task automatic wait_for(input string name, input int which, input logic lvl, input int limit);
    int n = 0;
    @(negedge masterClk);
    while (sig(which) !== lvl && n < limit) begin
      @(negedge masterClk);
      n++;
    end
    check(name, 32'(sig(which)), 32'(lvl));
  endtask

  // Pixel monitor: every pixel cycle pops one expected bit.
  initial begin
    int  run_len = 0;
    bit  prev_in = 0;
    bit  exp_bit;
    forever begin
      @(negedge masterClk);
      if (reset) begin
        run_len = 0;
        prev_in = 0;
      end else begin
        if (inputsInbound) begin
          run_len++;
          if (pix_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pixel_unexpected: got inputsInbound=1, expected no pending pixel at %0t", $time);
          end else begin
            exp_bit = pix_q.pop_front();
            check("pixel", 32'(inputPixel), 32'(exp_bit));
          end
          check("row_ready_in_stream", 32'(row_ready), 32'd0);
        end else begin
          if (prev_in) begin
            check("stream_len", 32'(run_len), 32'd784);
          end
          run_len = 0;
          check("pixel_idle", 32'(inputPixel), 32'd0);
        end
        prev_in = inputsInbound;
      end
    end
  end

  // Result monitor: each downstream handshake pops one expected result.
  initial begin
    res_t e;
    forever begin
      @(negedge masterClk);
      if (!reset && result_valid && result_ready) begin
        if (res_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL result_unexpected: got result_valid=1, expected no pending result at %0t", $time);
        end else begin
          e = res_q.pop_front();
          check("result_class", 32'(result_class), 32'(e.cls));
          check("result_err", 32'(result_err), 32'(e.err));
          check("image_count", 32'(image_count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge masterClk); #1;
    reset = 1'b1;
    pix_q.delete();
    res_q.delete();
    readyForInputs  = 1'b0;
    predictionReady = 1'b0;
    result_ready    = 1'b0;
    @(posedge masterClk); #1;
    reset     = 1'b0;
    exp_count = 16'd0;
    @(negedge masterClk);
    check("rst_row_ready", 32'(row_ready), 32'd1);
    check("rst_inbound", 32'(inputsInbound), 32'd0);
    check("rst_pixel", 32'(inputPixel), 32'd0);
    check("rst_pred_rcv", 32'(predictionRecieved), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_image_count", 32'(image_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic rand_img();
    for (int r = 0; r < H; r++) img_tb[r] = W'($urandom);
  endtask

  // Offers the rows of img_tb; reads row_ready only to pace the handshake.
  task automatic load_image(input bit keep_valid);
    for (int r = 0; r < H; r++) begin
      int n = 0;
      row_data  = img_tb[r];
      row_valid = 1'b1;
      while (!row_ready && n < 50) begin
        @(posedge masterClk); #1;
        n++;
      end
      check("row_accept_wait", 32'(row_ready), 32'd1);
      @(posedge masterClk); #1;
    end
    row_valid = keep_valid;
    row_data  = W'($urandom);
    @(negedge masterClk);
    check("row_ready_after_load", 32'(row_ready), 32'd0);
    check("busy_after_load", 32'(busy), 32'd1);
  endtask

  task automatic push_pixels();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix_q.push_back(img_tb[r][c]);
  endtask

  task automatic finish_result(input int res_delay);
    wait_for("result_valid_up", 2, 1'b1, 20);
    for (int i = 0; i < res_delay; i++) begin
      @(negedge masterClk);
      check("result_valid_hold", 32'(result_valid), 32'd1);
    end
    @(posedge masterClk); #1;
    result_ready = 1'b1;
    @(posedge masterClk); #1;
    result_ready = 1'b0;
    @(negedge masterClk);
    check("result_valid_clear", 32'(result_valid), 32'd0);
    check("row_ready_back", 32'(row_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_image(input int rfi_delay, input logic [3:0] cls, input int pred_hold,
                           input int res_delay, input bit keep_valid, input bit early_pred);
    push_pixels();
    readyForInputs = (rfi_delay == 0);
    load_image(keep_valid);
    if (rfi_delay > 0) begin
      for (int i = 0; i < rfi_delay; i++) begin
        @(negedge masterClk);
        check("no_stream_before_rfi", 32'(inputsInbound), 32'd0);
      end
      @(posedge masterClk); #1;
      readyForInputs = 1'b1;
      @(negedge masterClk);
      check("stream_not_yet", 32'(inputsInbound), 32'd0);
      @(negedge masterClk);
      check("stream_next_cycle", 32'(inputsInbound), 32'd1);
    end
    wait_for("stream_start", 0, 1'b1, 100);
    readyForInputs = 1'b0;
    if (early_pred) begin
      predictionOut   = cls;
      predictionReady = 1'b1;
    end
    wait_for("stream_end", 0, 1'b0, 900);
    exp_count = exp_count + 16'd1;
    res_q.push_back('{cls: cls, err: (int'(cls) >= N_CLASSES), cnt: exp_count});
    if (early_pred) begin
      @(negedge masterClk);
      check("early_pred_rcv", 32'(predictionRecieved), 32'd1);
      @(posedge masterClk); #1;
      predictionReady = 1'b0;
      wait_for("pred_rcv_drop", 1, 1'b0, 10);
    end else begin
      @(posedge masterClk); #1;
      predictionOut   = cls;
      predictionReady = 1'b1;
      @(negedge masterClk);
      check("pred_rcv_before_sample", 32'(predictionRecieved), 32'd0);
      @(negedge masterClk);
      check("pred_rcv_rise", 32'(predictionRecieved), 32'd1);
      for (int i = 0; i < pred_hold - 2; i++) begin
        @(negedge masterClk);
        check("pred_rcv_hold", 32'(predictionRecieved), 32'd1);
      end
      @(posedge masterClk); #1;
      predictionReady = 1'b0;
      @(negedge masterClk);
      check("pred_rcv_last", 32'(predictionRecieved), 32'd1);
      @(negedge masterClk);
      check("pred_rcv_fall", 32'(predictionRecieved), 32'd0);
      check("result_valid_after_ack", 32'(result_valid), 32'd1);
    end
    finish_result(res_delay);
  endtask

  task automatic run_abort();
    push_pixels();
    readyForInputs = 1'b1;
    load_image(1'b0);
    wait_for("abort_stream_start", 0, 1'b1, 100);
    readyForInputs = 1'b0;
    repeat (400) @(negedge masterClk);
    do_reset();
  endtask

  initial begin
    reset           = 1'b1;
    row_valid       = 1'b0;
    row_data        = '0;
    readyForInputs  = 1'b0;
    predictionReady = 1'b0;
    predictionOut   = 4'd0;
    result_ready    = 1'b0;
    exp_count       = 16'd0;
    repeat (3) @(posedge masterClk);
    do_reset();

    // Row-start pixel pattern, controller already idle, class 7.
    for (int r = 0; r < H; r++) img_tb[r] = 28'h0000001;
    run_image(0, 4'd7, 5, 0, 1'b0, 1'b0);

    // Controller busy for 50 cycles, illegal class 12, slow consumer.
    rand_img();
    run_image(50, 4'd12, 3, 10, 1'b0, 1'b0);

    // Reset mid-stream, then a fresh image must stream correctly.
    rand_img();
    run_abort();
    rand_img();
    run_image(0, 4'($urandom_range(9, 0)), 2, 2, 1'b0, 1'b1);

    // Back-to-back images with row_valid held high throughout.
    do_reset();
    row_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_img();
      run_image(i * 3, 4'($urandom_range(15, 0)), 2 + i, i, 1'b1, 1'b0);
    end
    row_valid = 1'b0;

    repeat (5) @(negedge masterClk);
    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
